// File: rtl/rst_wr_rd_seq_gen.sv
// Initiator for the reset/write/read window protocol: pulses a downstream reset,
// then issues one wr and one rd strobe at programmed window offsets, optionally looped.
module rst_wr_rd_seq_gen #(
  parameter int CNT_W   = 8,
  parameter int GUARD   = 2,
  parameter int MAX_WIN = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] rst_len,
  input  logic [CNT_W-1:0] wr_dly,
  input  logic [CNT_W-1:0] rd_dly,
  input  logic [CNT_W-1:0] loops,
  output logic             dut_rst,
  output logic             wr,
  output logic             rd,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic             aborted,
  output logic [CNT_W-1:0] loop_cnt
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RST    = 3'd1;
  localparam logic [2:0] S_GUARD  = 3'd2;
  localparam logic [2:0] S_GAP_WR = 3'd3;
  localparam logic [2:0] S_WR     = 3'd4;
  localparam logic [2:0] S_GAP_RD = 3'd5;
  localparam logic [2:0] S_RD     = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] GUARD_M1 = CNT_W'(GUARD - 1);
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(MAX_WIN - 1);
  localparam logic [CNT_W:0]   SUM_LAST = (CNT_W+1)'(MAX_WIN - 1);

  // Sum is one bit wider than the operands so 255+1+255 cannot wrap into range.
  function automatic logic cfg_legal(input logic [CNT_W-1:0] len,
                                     input logic [CNT_W-1:0] wdly,
                                     input logic [CNT_W-1:0] rdly);
    logic [CNT_W:0] sum;
    sum = {1'b0, wdly} + {{CNT_W{1'b0}}, 1'b1} + {1'b0, rdly};
    return (len != '0) && (wdly <= WIN_LAST) && (sum <= SUM_LAST);
  endfunction

  function automatic logic in_run(input logic [2:0] st);
    return (st != S_IDLE) && (st != S_DONE);
  endfunction

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] loop_cnt_q, loop_cnt_d;
  logic [CNT_W-1:0] rst_len_q, rst_len_d;
  logic [CNT_W-1:0] wr_dly_q, wr_dly_d;
  logic [CNT_W-1:0] rd_dly_q, rd_dly_d;
  logic [CNT_W-1:0] loops_q, loops_d;
  logic             dut_rst_q, dut_rst_d;
  logic             wr_q, wr_d;
  logic             rd_q, rd_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cfg_err_q, cfg_err_d;
  logic             aborted_q, aborted_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    loop_cnt_d = loop_cnt_q;
    rst_len_d  = rst_len_q;
    wr_dly_d   = wr_dly_q;
    rd_dly_d   = rd_dly_q;
    loops_d    = loops_q;
    cfg_err_d  = 1'b0;
    aborted_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_legal(rst_len, wr_dly, rd_dly)) begin
            rst_len_d  = rst_len;
            wr_dly_d   = wr_dly;
            rd_dly_d   = rd_dly;
            loops_d    = (loops == '0) ? ONE : loops;
            loop_cnt_d = '0;
            cnt_d      = rst_len - ONE;
            state_d    = S_RST;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      S_RST: begin
        if (cnt_q == '0) begin
          cnt_d   = GUARD_M1;
          state_d = S_GUARD;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      S_GUARD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - ONE;
        end else if (wr_dly_q == '0) begin
          state_d = S_WR;
        end else begin
          cnt_d   = wr_dly_q - ONE;
          state_d = S_GAP_WR;
        end
      end
      S_GAP_WR: begin
        if (cnt_q == '0) state_d = S_WR;
        else             cnt_d   = cnt_q - ONE;
      end
      S_WR: begin
        if (rd_dly_q == '0) begin
          loop_cnt_d = loop_cnt_q + ONE;
          state_d    = S_RD;
        end else begin
          cnt_d   = rd_dly_q - ONE;
          state_d = S_GAP_RD;
        end
      end
      S_GAP_RD: begin
        if (cnt_q == '0) begin
          loop_cnt_d = loop_cnt_q + ONE;
          state_d    = S_RD;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      S_RD: begin
        // loop_cnt never exceeds loops_q, so it cannot wrap even at loops=255.
        if (loop_cnt_q < loops_q) begin
          cnt_d   = rst_len_q - ONE;
          state_d = S_RST;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort && in_run(state_q)) begin
      state_d    = S_IDLE;
      cnt_d      = cnt_q;
      loop_cnt_d = loop_cnt_q;
      aborted_d  = 1'b1;
    end

    dut_rst_d = (state_d == S_RST);
    wr_d      = (state_d == S_WR);
    rd_d      = (state_d == S_RD);
    busy_d    = in_run(state_d);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      loop_cnt_q <= '0;
      dut_rst_q  <= 1'b0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      loop_cnt_q <= loop_cnt_d;
      dut_rst_q  <= dut_rst_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cfg_err_q  <= cfg_err_d;
      aborted_q  <= aborted_d;
    end
  end

  // Latched config is only consumed in run states, so it needs no reset.
  always_ff @(posedge clk) begin
    rst_len_q <= rst_len_d;
    wr_dly_q  <= wr_dly_d;
    rd_dly_q  <= rd_dly_d;
    loops_q   <= loops_d;
  end

  assign dut_rst  = dut_rst_q;
  assign wr       = wr_q;
  assign rd       = rd_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign cfg_err  = cfg_err_q;
  assign aborted  = aborted_q;
  assign loop_cnt = loop_cnt_q;

endmodule

// File: tb/tb_rst_wr_rd_seq_gen.sv
// Directed bench for rst_wr_rd_seq_gen; cycle index i means "after edge i" of the start edge.
module tb_rst_wr_rd_seq_gen;

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic [7:0] rst_len, wr_dly, rd_dly, loops;
  logic       dut_rst, wr, rd, busy, done, cfg_err, aborted;
  logic [7:0] loop_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  wire [6:0] obs = {dut_rst, wr, rd, busy, done, cfg_err, aborted};

  always #5 clk = ~clk;

  rst_wr_rd_seq_gen dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .rst_len(rst_len), .wr_dly(wr_dly), .rd_dly(rd_dly), .loops(loops),
    .dut_rst(dut_rst), .wr(wr), .rd(rd), .busy(busy), .done(done),
    .cfg_err(cfg_err), .aborted(aborted), .loop_cnt(loop_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [7:0] l, input logic [7:0] w,
                         input logic [7:0] r, input logic [7:0] n);
    rst_len = l; wr_dly = w; rd_dly = r; loops = n;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; abort = 1'b1;
    set_cfg(8'd2, 8'd0, 8'd1, 8'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (obs !== 7'b0 || loop_cnt !== 8'd0) begin
        n_bad++;
        $display("FAIL reset cyc%0d: outs=%b loop_cnt=%0d, want 0000000 / 0", i, obs, loop_cnt);
      end
    end
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    tick();
  endtask

  // Order: {dut_rst, wr, rd, busy, done, cfg_err, aborted}
  task automatic test_nominal();
    logic [6:0] e;
    set_cfg(8'd2, 8'd0, 8'd1, 8'd1);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) tick();
      e = {i <= 1, i == 4, i == 6, i <= 6, i == 7, 1'b0, 1'b0};
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL nominal cyc%0d: outs=%b want %b", i, obs, e);
      end
    end
    n_cmp++;
    if (loop_cnt !== 8'd1) begin
      n_bad++;
      $display("FAIL nominal loop_cnt: got %0d want 1", loop_cnt);
    end
  endtask

  task automatic test_window();
    logic [6:0] e;
    set_cfg(8'd1, 8'd9, 8'd0, 8'd1);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      e = {5'b0, i == 0, 1'b0};
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL window_reject cyc%0d: outs=%b want %b", i, obs, e);
      end
    end
    set_cfg(8'd1, 8'd8, 8'd0, 8'd1);
    start = 1'b1; tick(); start = 1'b0;
    set_cfg(8'd5, 8'd0, 8'd0, 8'd4);
    for (int i = 0; i < 15; i++) begin
      if (i > 0) tick();
      e = {i == 0, i == 11, i == 12, i <= 12, i == 13, 1'b0, 1'b0};
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL window_accept cyc%0d: outs=%b want %b", i, obs, e);
      end
    end
  endtask

  task automatic test_bad_rst_len();
    logic [6:0] e;
    set_cfg(8'd0, 8'd0, 8'd1, 8'd1);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      e = {5'b0, i == 0, 1'b0};
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL rst_len0 cyc%0d: outs=%b want %b", i, obs, e);
      end
    end
    set_cfg(8'd2, 8'd0, 8'd1, 8'd1);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) tick();
      e = {i <= 1, i == 4, i == 6, i <= 6, i == 7, 1'b0, 1'b0};
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL after_rst_len0 cyc%0d: outs=%b want %b", i, obs, e);
      end
    end
  endtask

  task automatic test_multi_loop();
    logic [6:0] e;
    logic [7:0] lc;
    int m;
    set_cfg(8'd2, 8'd0, 8'd0, 8'd3);
    start = 1'b1; tick(); start = 1'b0;
    set_cfg(8'd7, 8'd3, 8'd2, 8'd1);
    for (int i = 0; i < 20; i++) begin
      if (i > 0) tick();
      m  = i % 6;
      e  = {i < 18 && m <= 1, i < 18 && m == 4, i < 18 && m == 5, i <= 17, i == 18, 1'b0, 1'b0};
      lc = (i < 5) ? 8'd0 : (i < 11) ? 8'd1 : (i < 17) ? 8'd2 : 8'd3;
      n_cmp++;
      if (obs !== e || loop_cnt !== lc) begin
        n_bad++;
        $display("FAIL multi_loop cyc%0d: outs=%b cnt=%0d want %b cnt=%0d", i, obs, loop_cnt, e, lc);
      end
    end
  endtask

  task automatic test_abort();
    logic [6:0] e;
    logic [7:0] lc;
    abort = 1'b1; tick(); abort = 1'b0;
    n_cmp++;
    if (obs !== 7'b0) begin
      n_bad++;
      $display("FAIL abort_idle: outs=%b want 0000000", obs);
    end
    set_cfg(8'd2, 8'd0, 8'd1, 8'd2);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) tick();
      e  = {i == 0 || i == 1 || i == 7 || i == 8, i == 4 || i == 11, i == 6, i <= 11, 1'b0, 1'b0, i == 12};
      lc = (i < 6) ? 8'd0 : 8'd1;
      n_cmp++;
      if (obs !== e || loop_cnt !== lc) begin
        n_bad++;
        $display("FAIL abort cyc%0d: outs=%b cnt=%0d want %b cnt=%0d", i, obs, loop_cnt, e, lc);
      end
      abort = (i == 11);
    end
    abort = 1'b0;
    set_cfg(8'd2, 8'd0, 8'd1, 8'd1);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) tick();
      e  = {i <= 1, i == 4, i == 6, i <= 6, i == 7, 1'b0, 1'b0};
      lc = (i < 6) ? 8'd0 : 8'd1;
      n_cmp++;
      if (obs !== e || loop_cnt !== lc) begin
        n_bad++;
        $display("FAIL rerun_after_abort cyc%0d: outs=%b cnt=%0d want %b cnt=%0d", i, obs, loop_cnt, e, lc);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] e;
    set_cfg(8'd2, 8'd0, 8'd1, 8'd1);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 11; i++) begin
      if (i > 0) tick();
      e = (i <= 5) ? {i <= 1, i == 4, 1'b0, 1'b1, 3'b0} : 7'b0;
      n_cmp++;
      if (obs !== e || (i >= 6 && loop_cnt !== 8'd0)) begin
        n_bad++;
        $display("FAIL reset_mid cyc%0d: outs=%b cnt=%0d want %b cnt=0", i, obs, loop_cnt, e);
      end
      rst   = (i == 5 || i == 6);
      start = (i == 5 || i == 6);
      abort = (i == 5);
    end
    rst = 1'b0; start = 1'b0; abort = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [6:0] e;
    set_cfg(8'd2, 8'd0, 8'd1, 8'd1);
    start = 1'b1; tick();
    for (int i = 0; i < 19; i++) begin
      if (i > 0) tick();
      if (i <= 8) e = {i <= 1, i == 4, i == 6, i <= 6, i == 7, 1'b0, 1'b0};
      else        e = {i <= 10, i == 13, i == 15, i <= 15, i == 16, 1'b0, 1'b0};
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL back_to_back cyc%0d: outs=%b want %b", i, obs, e);
      end
      if (i == 9) start = 1'b0;
    end
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    set_cfg(8'd0, 8'd0, 8'd0, 8'd0);
    test_reset();
    test_nominal();
    test_window();
    test_bad_rst_len();
    test_multi_loop();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
